reg_rw_ctrl: RTL and testbench
==============================

# reg_rw_ctrl

Request/response front end for the register-array BRAM (single-port, write-first, 2-cycle read latency with output register) in the reg_dataRW extern. Accepts read/write requests from the P4 extern datapath, range-checks the index, drives the BRAM port, realigns its delayed output with per-request metadata, and buffers responses. A credit counter guarantees the response FIFO never overflows, so the BRAM pipeline never stalls.

## Interface
- L2_DEPTH, 8, log2 of BRAM entries; must match the BRAM instance
- WIDTH, 32, data width
- INDEX_W, 32, width of the request index as delivered by the extern
- CREDITS, 4, max requests accepted but not yet popped; response FIFO depth equals CREDITS
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready
- req_op  in  1  0 = read, 1 = write
- req_index  in  INDEX_W  register index
- req_data  in  WIDTH  write data; ignored for reads
- resp_valid  out  1  response at FIFO head
- resp_ready  in  1  consumer pops when valid & ready
- resp_data  out  WIDTH  read data, or written data for writes
- resp_err  out  1  index was out of range
- bram_en, bram_we  out  1 each  BRAM port enable and write enable
- bram_addr  out  L2_DEPTH  BRAM address
- bram_din  out  WIDTH  BRAM write data
- bram_regce  out  1  BRAM output register enable; tied to 1
- bram_rst  out  1  BRAM output register reset; equal to rst
- bram_dout  in  WIDTH  BRAM registered output

## Operation
- accept = req_valid & req_ready; req_ready = (credit_cnt < CREDITS) & ~rst.
- In-range: req_index < 2**L2_DEPTH, comparing the full INDEX_W bits.
- Combinational BRAM drive: bram_en = accept & in_range; bram_we = bram_en & req_op; bram_addr = req_index[L2_DEPTH-1:0]; bram_din = req_data.
- Out-of-range request: BRAM untouched. Still consumes a credit and still produces a response with resp_err = 1 and resp_data = 0 (read or write).
- Write response: resp_data = written data, taken from bram_dout because the BRAM is write-first.
- Metadata pipe: 2-stage shift register of {valid, err}, aligned with the BRAM read latency. When stage-2 valid, push {err ? 0 : bram_dout, err} into the response FIFO.
- credit_cnt: +1 on accept, −1 on pop. Both in the same cycle: unchanged. Width clog2(CREDITS+1).
- Response order equals request order; no reordering, no merging.

## Timing
- Request accepted in cycle T. BRAM samples address at the T edge; bram_dout is valid during T+2; FIFO push at the end of T+2; resp_valid is high from T+3. Fixed 3-cycle latency when the FIFO is empty.
- Throughput: 1 request/cycle sustained with resp_ready held high and CREDITS ≥ 4. With CREDITS < 4, throughput is limited to CREDITS per 4 cycles.
- Read-after-write to the same index in consecutive cycles returns the new data, because BRAM ports are sequential and write-first.
- FIFO full and empty: unreachable overflow by credit construction. Simultaneous push and pop when full is legal and keeps occupancy constant. Pop when empty cannot occur because resp_valid is 0.
- Outputs during and after reset: req_ready 0 during rst and 1 in the first cycle after. resp_valid 0, resp_data 0, resp_err 0, credit_cnt 0, metadata pipe cleared, FIFO emptied.
- Reset mid-operation: in-flight and buffered responses are discarded. BRAM contents are not restored, so writes already issued persist.
- resp_data and resp_err are stable while resp_valid & ~resp_ready.

## Structure
- Shared package reg_rw_pkg: OP_READ/OP_WRITE constants and a resp_t typedef {err, data}.
- Sub-module resp_fifo: synchronous FIFO, parameterised by depth and width, registered outputs, first-word valid the cycle after push.
- Top level: credit counter, range check, metadata pipe, BRAM drive.

## Test plan
- Write idx 5 = 0xDEADBEEF at T, read idx 5 at T+1 → two responses at T+3 and T+4, both 0xDEADBEEF with err 0.
- Read idx 256 with L2_DEPTH = 8 → resp_data 0, err 1. Write idx 0x100000 → err 1, and a following read of idx 0 is unchanged.
- Hold resp_ready low and issue 6 requests → exactly 4 accepted and req_ready falls. Release resp_ready → responses arrive in order and the remaining 2 are accepted.
- 64 back-to-back random read/write requests with resp_ready high → one accept per cycle, all data matches the scoreboard model.
- Random resp_ready toggling → no response lost or duplicated, credit_cnt never exceeds 4.
- Assert rst with 2 requests in flight and 2 buffered → resp_valid 0 the next cycle and no stale response after release. Data written before reset reads back.

Source files
------------

// File: rtl/reg_rw_pkg.sv
// reg_rw_pkg: shared opcodes and response record for the register-array front end.
package reg_rw_pkg;
    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;
    localparam int RESP_W = 32;
    typedef struct packed {
        logic              err;
        logic [RESP_W-1:0] data;
    } resp_t;
endpackage

// File: rtl/reg_rw_ctrl_if.sv
// reg_rw_ctrl_if: request/response handshake bundle between the extern datapath and the front end.
interface reg_rw_ctrl_if #(
    parameter int WIDTH   = 32,
    parameter int INDEX_W = 32
);
    logic               req_valid;
    logic               req_ready;
    logic               req_op;
    logic [INDEX_W-1:0] req_index;
    logic [WIDTH-1:0]   req_data;
    logic               resp_valid;
    logic               resp_ready;
    logic [WIDTH-1:0]   resp_data;
    logic               resp_err;
    modport master (
        output req_valid, req_op, req_index, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );
    modport slave (
        input  req_valid, req_op, req_index, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/reg_rw_ctrl_resp_fifo.sv
// resp_fifo: synchronous response FIFO; head word visible the cycle after push, zero when empty.
module resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] dout
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          do_pop;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign do_pop    = pop & valid;
    assign count_nxt = count + CW'(push) - CW'(do_pop);
    assign dout      = valid ? mem[rd_ptr] : '0;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count_nxt;
            valid <= count_nxt != '0;
        end
    end
endmodule

// File: rtl/reg_rw_ctrl.sv
// reg_rw_ctrl: range-checked BRAM request front end with credit-limited, in-order response buffering.
module reg_rw_ctrl
    import reg_rw_pkg::*;
#(
    parameter int L2_DEPTH = 8,
    parameter int WIDTH    = 32,
    parameter int INDEX_W  = 32,
    parameter int CREDITS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    reg_rw_ctrl_if.slave        bus,
    output logic                bram_en,
    output logic                bram_we,
    output logic [L2_DEPTH-1:0] bram_addr,
    output logic [WIDTH-1:0]    bram_din,
    output logic                bram_regce,
    output logic                bram_rst,
    input  logic [WIDTH-1:0]    bram_dout
);
    localparam int CW = $clog2(CREDITS + 1);
    logic [CW-1:0]  credit_cnt;
    logic           accept, pop, in_range;
    logic           v1, v2, e1, e2;
    logic [WIDTH:0] head;
    assign bus.req_ready = (credit_cnt < CW'(CREDITS)) & ~rst;
    assign accept        = bus.req_valid & bus.req_ready;
    assign pop           = bus.resp_valid & bus.resp_ready;
    assign in_range      = (bus.req_index >> L2_DEPTH) == '0;
    assign bram_en    = accept & in_range;
    assign bram_we    = bram_en & (bus.req_op == OP_WRITE);
    assign bram_addr  = bus.req_index[L2_DEPTH-1:0];
    assign bram_din   = bus.req_data;
    assign bram_regce = 1'b1;
    assign bram_rst   = rst;
    always_ff @(posedge clk) begin
        if (rst) credit_cnt <= '0;
        else credit_cnt <= credit_cnt + CW'(accept) - CW'(pop);
    end
    // Two stages match the BRAM read latency so err lines up with bram_dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            e1 <= 1'b0;
            v2 <= 1'b0;
            e2 <= 1'b0;
        end else begin
            v1 <= accept;
            e1 <= ~in_range;
            v2 <= v1;
            e2 <= e1;
        end
    end
    resp_fifo #(.DEPTH(CREDITS), .W(WIDTH + 1)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (v2),
        .din   ({e2, e2 ? '0 : bram_dout}),
        .pop   (bus.resp_ready),
        .valid (bus.resp_valid),
        .dout  (head)
    );
    assign {bus.resp_err, bus.resp_data} = head;
endmodule

// File: tb/tb_reg_rw_ctrl.sv
// tb_reg_rw_ctrl: vector table plus scoreboard bench for reg_rw_ctrl with a write-first 2-cycle BRAM model.
module tb_reg_rw_ctrl;
    import reg_rw_pkg::*;
    localparam int L2 = 8, W = 32, IW = 32, CR = 4;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    reg_rw_ctrl_if #(.WIDTH(W), .INDEX_W(IW)) bus ();
    logic          bram_en, bram_we, bram_regce, bram_rst;
    logic [L2-1:0] bram_addr;
    logic [W-1:0]  bram_din, bram_dout, bram_lat;

    reg_rw_ctrl #(.L2_DEPTH(L2), .WIDTH(W), .INDEX_W(IW), .CREDITS(CR)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_regce (bram_regce),
        .bram_rst   (bram_rst),
        .bram_dout  (bram_dout)
    );

    // Single-port write-first BRAM with an output register.
    logic [W-1:0] bram_mem [256];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                bram_mem[bram_addr] <= bram_din;
                bram_lat <= bram_din;
            end else bram_lat <= bram_mem[bram_addr];
        end
        if (bram_rst) bram_dout <= '0;
        else if (bram_regce) bram_dout <= bram_lat;
    end

    typedef struct {
        resp_t exp;
        int    cyc;
    } sb_t;
    typedef struct {
        logic          op;
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
        resp_t         exp;
    } vec_t;

    sb_t          q[$];
    sb_t          e;
    vec_t         tv[12];
    logic [W-1:0] ref_mem [256];
    int           n_vec = 0, n_err = 0, cyc = 0, outstanding = 0;
    bit           chk_lat = 0, tog_en = 0, prev_hold = 0, ok;
    logic [W:0]   prev_resp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic resp_t model(input logic op, input logic [IW-1:0] idx, input logic [W-1:0] d);
        resp_t r;
        if (idx >= 256) r = '{err: 1'b1, data: '0};
        else if (op == OP_WRITE) begin
            ref_mem[idx[7:0]] = d;
            r = '{err: 1'b0, data: d};
        end else r = '{err: 1'b0, data: ref_mem[idx[7:0]]};
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 so back-to-back calls issue one request per cycle.
    task automatic try_send(input logic op, input logic [IW-1:0] idx, input logic [W-1:0] d,
                            input bit has_exp, input resp_t texp, input int budget, output bit acc);
        resp_t m;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_index = idx;
        bus.req_data  = d;
        acc = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc = 1'b1;
                m = model(op, idx, d);
                q.push_back('{exp: has_exp ? texp : m, cyc: cyc});
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("ready_in_rst", bus.req_ready, 0);
            q.delete();
            outstanding = 0;
            prev_hold = 1'b0;
        end else begin
            chk("req_ready_credit", bus.req_ready, outstanding < CR);
            if (prev_hold) begin
                chk("hold_valid", bus.resp_valid, 1);
                chk("hold_resp", {bus.resp_err, bus.resp_data}, prev_resp);
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL stale_resp: got %0h with nothing outstanding", {bus.resp_err, bus.resp_data});
                end else begin
                    e = q.pop_front();
                    chk("resp", {bus.resp_err, bus.resp_data}, {e.exp.err, e.exp.data});
                    if (chk_lat) chk("latency", cyc - e.cyc, 3);
                end
            end
            outstanding += int'(bus.req_valid & bus.req_ready) - int'(bus.resp_valid & bus.resp_ready);
            prev_hold = bus.resp_valid & ~bus.resp_ready;
            prev_resp = {bus.resp_err, bus.resp_data};
        end
    end

    always @(posedge clk) if (tog_en) #1 bus.resp_ready = 1'($urandom_range(0, 1));

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            bram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        bram_lat = '0;
        tv[0]  = '{OP_WRITE, 32'd5,        32'hDEADBEEF, '{1'b0, 32'hDEADBEEF}};
        tv[1]  = '{OP_READ,  32'd5,        32'h0,        '{1'b0, 32'hDEADBEEF}};
        tv[2]  = '{OP_READ,  32'd256,      32'h0,        '{1'b1, 32'h0}};
        tv[3]  = '{OP_WRITE, 32'h100000,   32'h12345678, '{1'b1, 32'h0}};
        tv[4]  = '{OP_READ,  32'd0,        32'h0,        '{1'b0, 32'h0}};
        tv[5]  = '{OP_WRITE, 32'd0,        32'hA5A5A5A5, '{1'b0, 32'hA5A5A5A5}};
        tv[6]  = '{OP_READ,  32'd0,        32'h0,        '{1'b0, 32'hA5A5A5A5}};
        tv[7]  = '{OP_WRITE, 32'd255,      32'hFFFFFFFF, '{1'b0, 32'hFFFFFFFF}};
        tv[8]  = '{OP_READ,  32'd255,      32'h0,        '{1'b0, 32'hFFFFFFFF}};
        tv[9]  = '{OP_READ,  32'hFFFFFFFF, 32'h0,        '{1'b1, 32'h0}};
        tv[10] = '{OP_WRITE, 32'd256,      32'h00000001, '{1'b1, 32'h0}};
        tv[11] = '{OP_READ,  32'd0,        32'h0,        '{1'b0, 32'hA5A5A5A5}};
        bus.req_valid = 1'b0;
        bus.req_op = OP_READ;
        bus.req_index = '0;
        bus.req_data = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", bus.req_ready, 1);
        @(posedge clk);
        #1;

        chk_lat = 1'b1;
        foreach (tv[i]) begin
            try_send(tv[i].op, tv[i].idx, tv[i].data, 1'b1, tv[i].exp, 1, ok);
            chk("table_accept", ok, 1);
        end
        drain();

        chk_lat = 1'b0;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            try_send(OP_READ, 32'(i), '0, 1'b0, '0, 1, ok);
            chk("credit_accept", ok, 1);
        end
        try_send(OP_WRITE, 32'd7, 32'h77777777, 1'b0, '0, 8, ok);
        chk("credit_block", ok, 0);
        chk("credit_ready_low", bus.req_ready, 0);
        bus.resp_ready = 1'b1;
        try_send(OP_WRITE, 32'd7, 32'h77777777, 1'b0, '0, 10, ok);
        chk("credit_resume5", ok, 1);
        try_send(OP_READ, 32'd7, '0, 1'b0, '0, 10, ok);
        chk("credit_resume6", ok, 1);
        drain();

        chk_lat = 1'b1;
        for (int i = 0; i < 64; i++) begin
            logic [IW-1:0] idx;
            idx = ($urandom_range(0, 9) == 0) ? 32'(256 + $urandom_range(0, 1000)) : 32'($urandom_range(0, 15));
            try_send(1'($urandom_range(0, 1)), idx, $urandom, 1'b0, '0, 1, ok);
            chk("b2b_accept", ok, 1);
        end
        drain();

        chk_lat = 1'b0;
        tog_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            try_send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom, 1'b0, '0, 60, ok);
            chk("toggle_accept", ok, 1);
        end
        tog_en = 1'b0;
        @(posedge clk);
        #2 bus.resp_ready = 1'b1;
        drain();

        bus.resp_ready = 1'b0;
        try_send(OP_WRITE, 32'd10, 32'h11110000, 1'b0, '0, 1, ok);
        try_send(OP_WRITE, 32'd20, 32'h22220000, 1'b0, '0, 1, ok);
        repeat (4) @(posedge clk);
        #1;
        try_send(OP_WRITE, 32'd11, 32'h33330000, 1'b0, '0, 1, ok);
        try_send(OP_WRITE, 32'd12, 32'h44440000, 1'b0, '0, 1, ok);
        chk("rst_seq_accept", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", bus.resp_valid, 0);
        chk("post_rst_data", bus.resp_data, 0);
        chk("post_rst_err", bus.resp_err, 0);
        chk("post_rst_ready", bus.req_ready, 1);
        bus.resp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk_lat = 1'b1;
        try_send(OP_READ, 32'd10, '0, 1'b1, '{1'b0, 32'h11110000}, 1, ok);
        try_send(OP_READ, 32'd20, '0, 1'b1, '{1'b0, 32'h22220000}, 1, ok);
        try_send(OP_READ, 32'd11, '0, 1'b1, '{1'b0, 32'h33330000}, 1, ok);
        try_send(OP_READ, 32'd12, '0, 1'b1, '{1'b0, 32'h44440000}, 1, ok);
        chk("readback_accept", ok, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
